pll_lock_supervisor: RTL
========================

# pll_lock_supervisor

Sequencer for one PolarFire CCC/PLL instance: drives the PLL's active-low powerdown input, waits for lock with a timeout and bounded retries, and qualifies lock as stable. It then releases a reset to the logic clocked by the PLL output, and restarts the PLL if lock is lost. It sits beside each PLL wrapper and runs on the free-running reference/system clock, never on the PLL output.

## Interface
- PD_CYCLES, 64: cycles the PLL is held in powerdown before each lock attempt (≥2)
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the attempt fails
- LOCK_STABLE, 256: consecutive synchronized-lock cycles required before RUN
- MAX_RETRIES, 3: failed attempts tolerated; the MAX_RETRIES-th timeout enters FAULT
- RST_HOLD, 16: cycles Fabric_Reset stays asserted after entering RUN
- Clock  in  1  free-running system clock
- Reset  in  1  asynchronous, active-high
- Enable  in  1  level; 1 = PLL requested on
- Restart  in  1  single-cycle pulse; forces a fresh power cycle and clears the retry count
- PLL_LOCK  in  1  raw PLL lock, asynchronous; synchronized internally with 2 flops
- PLL_POWERDOWN_N  out  1  to PLL; 0 = powered down
- Fabric_Reset  out  1  active-high reset for PLL-domain logic; consumers resynchronize it
- Locked  out  1  1 only in RUN
- Fault  out  1  1 only in FAULT
- Lost_Lock  out  1  one-cycle pulse on lock loss in RUN
- Retry_Count  out  clog2(MAX_RETRIES+1)  failed attempts since the last RUN, Restart or OFF
- State  out  3  current state encoding (debug)

## Operation
- States: OFF=0, POWERDOWN=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5. One shared cycle counter is cleared on every state entry.
- Transition priority each cycle:
  - Enable=0 → OFF.
  - else Restart=1 (state ≠ OFF) → POWERDOWN, Retry_Count←0.
  - else state rules below.
- OFF: PLL_POWERDOWN_N=0, Fabric_Reset=1, Retry_Count←0. Enable=1 → POWERDOWN.
- POWERDOWN: PLL_POWERDOWN_N=0. Counter reaches PD_CYCLES-1 → WAIT_LOCK.
- WAIT_LOCK: PLL_POWERDOWN_N=1.
  - lock_s=1 → STABLE.
  - else counter reaches LOCK_TIMEOUT-1 → Retry_Count+1. If the new value = MAX_RETRIES → FAULT, else → POWERDOWN.
- STABLE: lock_s=0 → WAIT_LOCK (timeout restarts from 0, no retry increment). Counter reaches LOCK_STABLE-1 with lock_s=1 → RUN, Retry_Count←0.
- RUN: Locked=1. Fabric_Reset=1 until the counter reaches RST_HOLD-1, then 0; the counter saturates. lock_s=0 → Lost_Lock pulse, Fabric_Reset=1, → POWERDOWN.
- FAULT: PLL_POWERDOWN_N=0, Fault=1. Exit only via Restart or Enable=0.
- Fabric_Reset=1 in every state except RUN after the hold. Retry_Count saturates at MAX_RETRIES.

## Timing
- Reset values: State=OFF, PLL_POWERDOWN_N=0, Fabric_Reset=1, Locked=0, Fault=0, Lost_Lock=0, Retry_Count=0, sync flops=0.
- All outputs are registered and change on the cycle the state register updates. No combinational path from inputs to outputs.
- PLL_LOCK → lock_s latency: 2 cycles. The FSM reacts on the following edge.
- Enable rising at edge N → POWERDOWN at N+1 → WAIT_LOCK at N+1+PD_CYCLES (PLL_POWERDOWN_N rises at that edge).
- Lock is qualified LOCK_STABLE cycles after entering STABLE. Fabric_Reset falls RST_HOLD cycles after entering RUN.
- Lock drop in RUN: Locked falls and Fabric_Reset rises 3 edges after PLL_LOCK falls (2 sync + 1 state).
- Reset asserted mid-operation: immediate asynchronous return to reset values. PLL is powered down.
- Restart and timeout in the same cycle: Restart wins and the retry is not counted.

## Structure
- Shared package pll_sup_pkg: state encoding constants, the state width (3), and a clog2 function.
- Sub-module sync_2ff, a generic 1-bit two-flop synchronizer with async reset to 0, instantiated for PLL_LOCK.
- Counter width: clog2(max(PD_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, RST_HOLD)).

## Test plan
All scenarios use PD_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=2, RST_HOLD=4.
- Nominal bring-up: Enable=1 at cycle 0, PLL model raises lock 20 cycles after PLL_POWERDOWN_N rises → PLL_POWERDOWN_N rises at cycle 5, Locked=1 at cycle 5+20+2+1+8, Fabric_Reset=0 four cycles later, Retry_Count=0.
- Timeout to FAULT: lock never rises → two 100-cycle WAIT_LOCK windows separated by 4-cycle powerdowns, then Fault=1, Retry_Count=2, PLL_POWERDOWN_N=0.
- Glitchy lock: lock high for 5 cycles then low during STABLE → back to WAIT_LOCK with no Retry_Count change. A later 8-cycle stable lock reaches RUN.
- Loss in RUN: drop PLL_LOCK → one-cycle Lost_Lock, Fabric_Reset=1 and Locked=0 within 3 cycles, PLL_POWERDOWN_N=0 for 4 cycles, then re-lock.
- Restart from FAULT and mid-WAIT_LOCK: Restart pulse → POWERDOWN next cycle, Retry_Count=0, Fault=0. Restart coincident with a timeout → no increment.
- Async Reset asserted in RUN, and Enable=0 in each state → all outputs at reset values / OFF on the next edge, PLL_POWERDOWN_N=0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared constants for the PLL lock supervisor: state encoding, state width
// and a constant-evaluable clog2 used to size counters and ports.
package pll_sup_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_OFF       = 3'd0;
   localparam logic [STATE_W-1:0] ST_POWERDOWN = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [STATE_W-1:0] ST_STABLE    = 3'd3;
   localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;
   localparam logic [STATE_W-1:0] ST_FAULT     = 3'd5;

   // Never returns 0, so a degenerate parameter still yields a 1-bit vector.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Power-up / lock-qualification sequencer for one CCC/PLL, clocked by the
// free-running system clock; releases the PLL-domain reset once lock is stable.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PD_CYCLES    = 64,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRIES  = 3,
   parameter int RST_HOLD     = 16
) (
   input  logic                                 Clock,
   input  logic                                 Reset,
   input  logic                                 Enable,
   input  logic                                 Restart,
   input  logic                                 PLL_LOCK,
   output logic                                 PLL_POWERDOWN_N,
   output logic                                 Fabric_Reset,
   output logic                                 Locked,
   output logic                                 Fault,
   output logic                                 Lost_Lock,
   output logic [clog2(MAX_RETRIES+1)-1:0]      Retry_Count,
   output logic [STATE_W-1:0]                   State
);

   localparam int CNT_MAX_A = (PD_CYCLES > LOCK_TIMEOUT) ? PD_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX_B = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
   localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
   localparam int CNT_W     = clog2(CNT_MAX);
   localparam int RC_W      = clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE - 1);
   localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRIES);

   logic                lock_s;
   logic [STATE_W-1:0]  state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RC_W-1:0]     retry_q, retry_d;
   logic                enter, lost;
   logic                pd_n_q, pd_n_d;
   logic                fab_rst_q, fab_rst_d;
   logic                locked_q, locked_d;
   logic                fault_q, fault_d;
   logic                lost_q;

   sync_2ff u_lock_sync (
      .clk_i (Clock),
      .rst_i (Reset),
      .d_i   (PLL_LOCK),
      .q_o   (lock_s)
   );

   // enter marks any state entry, including a Restart back into POWERDOWN.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      enter   = 1'b0;
      lost    = 1'b0;
      if (!Enable) begin
         state_d = ST_OFF;
         retry_d = '0;
         enter   = (state_q != ST_OFF);
      end else if (Restart && (state_q != ST_OFF)) begin
         state_d = ST_POWERDOWN;
         retry_d = '0;
         enter   = 1'b1;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_POWERDOWN;
               retry_d = '0;
               enter   = 1'b1;
            end
            ST_POWERDOWN:
               if (cnt_q == PD_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  enter   = 1'b1;
               end
            ST_WAIT_LOCK:
               if (lock_s) begin
                  state_d = ST_STABLE;
                  enter   = 1'b1;
               end else if (cnt_q == TO_LAST) begin
                  if (retry_q != RC_MAX) retry_d = retry_q + 1'b1;
                  state_d = (retry_d == RC_MAX) ? ST_FAULT : ST_POWERDOWN;
                  enter   = 1'b1;
               end
            ST_STABLE:
               if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
                  enter   = 1'b1;
               end else if (cnt_q == LS_LAST) begin
                  state_d = ST_RUN;
                  retry_d = '0;
                  enter   = 1'b1;
               end
            ST_RUN:
               if (!lock_s) begin
                  state_d = ST_POWERDOWN;
                  lost    = 1'b1;
                  enter   = 1'b1;
               end
            ST_FAULT: ;
            default: begin
               state_d = ST_OFF;
               enter   = 1'b1;
            end
         endcase
      end
   end

   // Counter holds in OFF/FAULT and saturates in RUN once the reset hold is done.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (enter)
         cnt_d = '0;
      else if ((state_q == ST_OFF) || (state_q == ST_FAULT))
         cnt_d = cnt_q;
      else if ((state_q == ST_RUN) && (cnt_q == RH_LAST))
         cnt_d = cnt_q;
   end

   always_comb begin
      pd_n_d    = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
      fab_rst_d = !((state_d == ST_RUN) && !enter && (cnt_q == RH_LAST));
      locked_d  = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         retry_q   <= '0;
         pd_n_q    <= 1'b0;
         fab_rst_q <= 1'b1;
         locked_q  <= 1'b0;
         fault_q   <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         pd_n_q    <= pd_n_d;
         fab_rst_q <= fab_rst_d;
         locked_q  <= locked_d;
         fault_q   <= fault_d;
         lost_q    <= lost;
      end
   end

   assign PLL_POWERDOWN_N = pd_n_q;
   assign Fabric_Reset    = fab_rst_q;
   assign Locked          = locked_q;
   assign Fault           = fault_q;
   assign Lost_Lock       = lost_q;
   assign Retry_Count     = retry_q;
   assign State           = state_q;

endmodule
